// File: rtl/opr2_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : opr2_sequencer
// Brief    : Steps a PDP-8/E group-2 operate microinstruction through its
//            skip-test/CLA, OSR and HLT event phases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module opr2_sequencer #(
   parameter int USER_TRAP_EN = 1
) (
   input  logic        clk100,
   input  logic        reset,
   input  logic        start,
   input  logic [0:11] instruction,
   input  logic [0:11] ac,
   input  logic        l,
   input  logic [0:11] sr,
   input  logic        user_mode,
   input  logic        cont,
   output logic [0:11] ac_out,
   output logic        ac_wr,
   output logic        skip,
   output logic        halt,
   output logic        trap,
   output logic        busy,
   output logic        done
);

   localparam logic c_trap_en = (USER_TRAP_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EVAL = 3'd1,
      S_OSR  = 3'd2,
      S_HALT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   // Only the microinstruction bits that steer the sequence are kept.
   logic [4:10] r_ir;
   logic [0:11] r_ac;
   logic [0:11] r_ac_out;
   logic        r_l;
   logic        r_user;
   logic        r_ac_zero;
   logic        r_skip;

   logic        w_group2;
   logic        w_accept;
   logic        w_sma;
   logic        w_sza;
   logic        w_snl;
   logic        w_any;
   logic        w_skip_eval;
   logic        w_trap_eval;
   logic [0:11] w_ac_next;
   logic [0:11] w_ac_out;

   assign w_group2 = (instruction[0:3] == 4'b1111) && !instruction[11];
   assign w_accept = start && w_group2 && (r_state == S_IDLE);

   // Skip tests always see the captured AC; CLA lands in r_ac only after EVAL.
   assign w_sma       = r_ir[5] & r_ac[0];
   assign w_sza       = r_ir[6] & r_ac_zero;
   assign w_snl       = r_ir[7] & r_l;
   assign w_any       = w_sma | w_sza | w_snl;
   assign w_skip_eval = r_ir[8] ? !w_any : w_any;
   assign w_trap_eval = c_trap_en && r_user && (r_ir[9] || r_ir[10]);

   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         r_ir      <= '0;
         r_ac      <= '0;
         r_l       <= 1'b0;
         r_user    <= 1'b0;
         r_ac_zero <= 1'b0;
         r_skip    <= 1'b0;
         r_ac_out  <= '0;
      end else begin
         r_ac_out <= w_ac_out;
         if (w_accept) begin
            r_ir      <= instruction[4:10];
            r_ac      <= ac;
            r_l       <= l;
            r_user    <= user_mode;
            r_ac_zero <= (ac == 12'd0);
         end else begin
            r_ac <= w_ac_next;
         end
         if (r_state == S_EVAL) begin
            r_skip <= w_skip_eval;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ac_next = r_ac;
      w_ac_out  = r_ac_out;
      ac_wr     = 1'b0;
      skip      = 1'b0;
      halt      = 1'b0;
      trap      = 1'b0;
      done      = 1'b0;
      busy      = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_EVAL;
            end
         end

         S_EVAL: begin
            if (r_ir[4]) begin
               w_ac_out  = 12'd0;
               w_ac_next = 12'd0;
               ac_wr     = 1'b1;
            end
            // A trapped OSR/HLT still lets the skip test and CLA complete.
            if (w_trap_eval) begin
               trap   = 1'b1;
               w_next = S_DONE;
            end else if (r_ir[9]) begin
               w_next = S_OSR;
            end else if (r_ir[10]) begin
               w_next = S_HALT;
            end else begin
               w_next = S_DONE;
            end
         end

         S_OSR: begin
            w_ac_out  = r_ac | sr;
            w_ac_next = r_ac | sr;
            ac_wr     = 1'b1;
            w_next    = r_ir[10] ? S_HALT : S_DONE;
         end

         S_HALT: begin
            halt = 1'b1;
            if (cont) begin
               w_next = S_DONE;
            end
         end

         S_DONE: begin
            done   = 1'b1;
            skip   = r_skip;
            w_next = S_IDLE;
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign ac_out = w_ac_out;

endmodule
`default_nettype wire

// File: tb/tb_opr2_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_opr2_sequencer
// Brief    : Vector table, directed corner sequences and random instructions
//            checked against a behavioural model of the group-2 sequence.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_opr2_sequencer;

   logic        clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   logic        reset, start, l, user_mode, cont, sel;
   logic [0:11] instruction, ac, sr;
   logic        start_a, start_b;

   logic [0:11] a_ac_out, b_ac_out;
   logic        a_ac_wr, a_skip, a_halt, a_trap, a_busy, a_done;
   logic        b_ac_wr, b_skip, b_halt, b_trap, b_busy, b_done;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   opr2_sequencer #(.USER_TRAP_EN(1)) dut_a (
      .clk100(clk100), .reset(reset), .start(start_a), .instruction(instruction),
      .ac(ac), .l(l), .sr(sr), .user_mode(user_mode), .cont(cont),
      .ac_out(a_ac_out), .ac_wr(a_ac_wr), .skip(a_skip), .halt(a_halt),
      .trap(a_trap), .busy(a_busy), .done(a_done));

   opr2_sequencer #(.USER_TRAP_EN(0)) dut_b (
      .clk100(clk100), .reset(reset), .start(start_b), .instruction(instruction),
      .ac(ac), .l(l), .sr(sr), .user_mode(user_mode), .cont(cont),
      .ac_out(b_ac_out), .ac_wr(b_ac_wr), .skip(b_skip), .halt(b_halt),
      .trap(b_trap), .busy(b_busy), .done(b_done));

   logic [0:11] w_ac_out;
   logic        w_ac_wr, w_skip, w_halt, w_trap, w_busy, w_done;
   assign w_ac_out = sel ? b_ac_out : a_ac_out;
   assign w_ac_wr  = sel ? b_ac_wr  : a_ac_wr;
   assign w_skip   = sel ? b_skip   : a_skip;
   assign w_halt   = sel ? b_halt   : a_halt;
   assign w_trap   = sel ? b_trap   : a_trap;
   assign w_busy   = sel ? b_busy   : a_busy;
   assign w_done   = sel ? b_done   : a_done;

   typedef struct {
      logic [0:11] instr;
      logic [0:11] ac;
      logic [0:11] sr;
      logic        l;
      logic        user;
      logic        sel;
      int          hold;     // HALT cycles before cont is seen
      int          intrude;  // cycle at which a second start is pulsed (0 = none)
      logic        e_skip;
      int          e_nwr;
      logic [0:11] e_wr0;
      logic [0:11] e_wr1;
      int          e_trap;
      int          e_halt;
      int          e_done;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [0:11] hist [2];
   vec_t        tbl [16];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0o expected %0o (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [0:11] i, input logic [0:11] a,
                               input logic [0:11] s, input logic ll, input logic u,
                               input logic sl, input int hold, input int intr,
                               input logic e_skip, input int e_nwr,
                               input logic [0:11] e_wr0, input logic [0:11] e_wr1,
                               input int e_trap, input int e_halt, input int e_done);
      vec_t v;
      v.instr = i; v.ac = a; v.sr = s; v.l = ll; v.user = u; v.sel = sl;
      v.hold = hold; v.intrude = intr;
      v.e_skip = e_skip; v.e_nwr = e_nwr; v.e_wr0 = e_wr0; v.e_wr1 = e_wr1;
      v.e_trap = e_trap; v.e_halt = e_halt; v.e_done = e_done;
      return v;
   endfunction

   // Reference: what a group-2 word does, phase by phase, in plain arithmetic.
   function automatic vec_t model(input vec_t vi);
      vec_t        v;
      logic [0:11] i;
      logic [0:11] work;
      logic        cond, trapped, do_osr, do_hlt;
      v = vi;
      i = v.instr;
      cond = (i[5] && v.ac[0]) || (i[6] && (v.ac == 12'o0000)) || (i[7] && v.l);
      v.e_skip = i[8] ? !cond : cond;
      trapped  = (v.sel == 1'b0) && v.user && (i[9] || i[10]);
      do_osr   = !trapped && i[9];
      do_hlt   = !trapped && i[10];
      work     = v.ac;
      v.e_nwr  = 0;
      v.e_wr0  = 12'o0000;
      v.e_wr1  = 12'o0000;
      if (i[4]) begin
         work    = 12'o0000;
         v.e_wr0 = 12'o0000;
         v.e_nwr = 1;
      end
      if (do_osr) begin
         if (v.e_nwr == 0) v.e_wr0 = work | v.sr;
         else              v.e_wr1 = work | v.sr;
         v.e_nwr = v.e_nwr + 1;
      end
      v.e_trap = trapped ? 1 : 0;
      v.e_halt = do_hlt ? v.hold : 0;
      v.e_done = 2 + (do_osr ? 1 : 0) + (do_hlt ? v.hold : 0);
      return v;
   endfunction

   // Starts one instruction just after a negedge and follows it to completion.
   task automatic run_vec(input vec_t v, input string nm);
      int          done_cyc = -1;
      int          nwr = 0, ntrap = 0, trap_cyc = 0, hcnt = 0;
      int          busy_bad = 0, skip_bad = 0;
      logic        skip_seen = 1'b0;
      logic [0:11] wr0 = 12'o0, wr1 = 12'o0, held = 12'o0, exp_hold;
      logic [2:0]  post;
      instruction = v.instr; ac = v.ac; sr = v.sr; l = v.l; user_mode = v.user;
      sel = v.sel; cont = 1'b0; start = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk100);
         if (cyc == 1) start = 1'b0;
         if (v.intrude != 0 && cyc == v.intrude) begin
            start = 1'b1; instruction = 12'o7640; ac = 12'o0000;
         end
         if (v.intrude != 0 && cyc == v.intrude + 1) start = 1'b0;
         if (!w_busy) busy_bad++;
         if (w_skip && !w_done) skip_bad++;
         if (w_ac_wr) begin
            if (nwr == 0) wr0 = w_ac_out;
            else if (nwr == 1) wr1 = w_ac_out;
            nwr++;
         end
         if (w_trap) begin ntrap++; trap_cyc = cyc; end
         if (w_halt) begin
            hcnt++;
            if (hcnt >= v.hold) cont = 1'b1;
         end
         if (w_done) begin
            done_cyc = cyc; skip_seen = w_skip; held = w_ac_out;
            break;
         end
      end
      @(negedge clk100);
      post  = {w_busy, w_done, w_skip};
      start = 1'b0;
      cont  = 1'b0;

      chk({nm, " done_cycle"}, done_cyc, v.e_done);
      chk({nm, " skip"}, int'(skip_seen), int'(v.e_skip));
      chk({nm, " ac_wr_count"}, nwr, v.e_nwr);
      if (v.e_nwr >= 1) chk({nm, " ac_wr0"}, int'(wr0), int'(v.e_wr0));
      if (v.e_nwr >= 2) chk({nm, " ac_wr1"}, int'(wr1), int'(v.e_wr1));
      chk({nm, " trap_count"}, ntrap, v.e_trap);
      if (v.e_trap > 0) chk({nm, " trap_cycle"}, trap_cyc, 1);
      chk({nm, " halt_cycles"}, hcnt, v.e_halt);
      exp_hold = (v.e_nwr >= 2) ? v.e_wr1 : (v.e_nwr == 1) ? v.e_wr0 : hist[v.sel];
      hist[v.sel] = exp_hold;
      chk({nm, " ac_out_hold"}, int'(held), int'(exp_hold));
      chk({nm, " busy_gap"}, busy_bad, 0);
      chk({nm, " skip_outside_done"}, skip_bad, 0);
      chk({nm, " idle_after_done"}, int'(post), 0);
   endtask

   initial begin
      vec_t v;
      int   err_cnt;
      reset = 1'b0; start = 1'b0; l = 1'b0; user_mode = 1'b0; cont = 1'b0; sel = 1'b0;
      instruction = 12'o0; ac = 12'o0; sr = 12'o0;
      hist[0] = 12'o0; hist[1] = 12'o0;

      //         instr    ac       sr      l   u   sel hold intr  skip nwr wr0     wr1   trap halt done
      tbl[0]  = mk(12'o7500, 12'o4000, 12'o0000, 0, 0, 0, 1, 0,  1, 0, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[1]  = mk(12'o7510, 12'o4000, 12'o0000, 0, 0, 0, 1, 0,  0, 0, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[2]  = mk(12'o7410, 12'o0001, 12'o0000, 0, 0, 0, 1, 0,  1, 0, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[3]  = mk(12'o7640, 12'o0000, 12'o0000, 0, 0, 0, 1, 0,  1, 1, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[4]  = mk(12'o7640, 12'o0005, 12'o0000, 0, 0, 0, 1, 0,  0, 1, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[5]  = mk(12'o7604, 12'o7777, 12'o1234, 0, 0, 0, 1, 0,  0, 2, 12'o0000, 12'o1234, 0, 0, 3);
      tbl[6]  = mk(12'o7404, 12'o0700, 12'o0017, 0, 0, 0, 1, 0,  0, 1, 12'o0717, 12'o0000, 0, 0, 3);
      tbl[7]  = mk(12'o7402, 12'o0000, 12'o0000, 0, 0, 0, 10, 0, 0, 0, 12'o0000, 12'o0000, 0, 10, 12);
      tbl[8]  = mk(12'o7406, 12'o0123, 12'o0456, 0, 1, 0, 2, 0,  0, 0, 12'o0000, 12'o0000, 1, 0, 2);
      tbl[9]  = mk(12'o7406, 12'o0123, 12'o0456, 0, 1, 1, 3, 0,  0, 1, 12'o0577, 12'o0000, 0, 3, 6);
      tbl[10] = mk(12'o7430, 12'o0000, 12'o0000, 1, 0, 0, 1, 0,  0, 0, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[11] = mk(12'o7644, 12'o0000, 12'o7777, 0, 1, 0, 1, 0,  1, 1, 12'o0000, 12'o0000, 1, 0, 2);
      tbl[12] = mk(12'o7402, 12'o0000, 12'o0000, 0, 0, 0, 1, 0,  0, 0, 12'o0000, 12'o0000, 0, 1, 3);
      tbl[13] = mk(12'o7402, 12'o0000, 12'o0000, 0, 0, 0, 6, 4,  0, 0, 12'o0000, 12'o0000, 0, 6, 8);
      tbl[14] = mk(12'o7500, 12'o4000, 12'o0000, 0, 0, 0, 1, 1,  1, 0, 12'o0000, 12'o0000, 0, 0, 2);
      tbl[15] = mk(12'o7604, 12'o7777, 12'o1234, 0, 0, 0, 1, 3,  0, 2, 12'o0000, 12'o1234, 0, 0, 3);

      // Reset values with reset held, then released away from the clock edge
      repeat (3) @(negedge clk100);
      chk("reset_outputs", int'({a_ac_out, a_ac_wr, a_skip, a_halt, a_trap, a_busy, a_done,
                                 b_ac_out, b_ac_wr, b_skip, b_halt, b_trap, b_busy, b_done}), 0);
      reset = 1'b1;
      @(negedge clk100);

      // Non-group-2 word must be ignored
      instruction = 12'o7200; ac = 12'o0000; sel = 1'b0; start = 1'b1;
      @(negedge clk100);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("group1_ignored", int'({w_busy, w_ac_wr, w_done, w_halt, w_trap}), 0);
         @(negedge clk100);
      end

      for (int k = 0; k < 16; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

      // Reset asserted while halted aborts at once with no done pulse
      instruction = 12'o7402; ac = 12'o0000; sel = 1'b0; user_mode = 1'b0; cont = 1'b0;
      start = 1'b1;
      @(negedge clk100);
      start = 1'b0;
      repeat (3) @(negedge clk100);
      chk("halt_before_reset", int'(w_halt), 1);
      #2 reset = 1'b0;
      #1;
      chk("reset_in_halt", int'({w_halt, w_busy, w_done}), 0);
      chk("reset_ac_out", int'(w_ac_out), 0);
      err_cnt = 0;
      repeat (3) begin
         @(negedge clk100);
         if (w_done || w_busy) err_cnt++;
      end
      chk("no_done_after_reset", err_cnt, 0);
      reset = 1'b1;
      hist[0] = 12'o0; hist[1] = 12'o0;
      @(negedge clk100);
      run_vec(tbl[0], "after_reset");

      // Random group-2 words against the model, on both trap configurations
      for (int k = 0; k < 150; k++) begin
         v.instr   = {4'b1111, 7'($urandom), 1'b0};
         v.ac      = ($urandom_range(0, 3) == 0) ? 12'o0000 : 12'($urandom);
         v.sr      = 12'($urandom);
         v.l       = 1'($urandom);
         v.user    = 1'($urandom);
         v.sel     = 1'($urandom);
         v.hold    = int'($urandom_range(1, 4));
         v.intrude = 0;
         v = model(v);
         run_vec(v, $sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/opr2_sequencer.md
Name: opr2_sequencer

Overview:
Sequences execution of a PDP-8/E group-2 operate microinstruction across its event phases. The phases are, in order: skip test, CLA, OSR and HLT.
- Sits between the major-state controller and the accumulator/PC datapath.
- Accepts a start pulse with the decoded instruction and the AC/L snapshot.
- Issues AC write strobes and a skip (PC increment) request, holds in halt until continued, and reports done.
- Raises a user-mode trap for privileged OSR/HLT.

Parameters:
USER_TRAP_EN, 1, when 1 the user_mode input enables trapping of OSR/HLT; when 0 user_mode is ignored.

Ports:
clk100  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to execute instruction
instruction  input  [0:11]  instruction word, sampled on start
ac  input  [0:11]  accumulator, sampled on start
l  input  1  link, sampled on start
sr  input  [0:11]  front-panel switch register, sampled in OSR state
user_mode  input  1  time-share user mode, sampled on start
cont  input  1  level, releases halt
ac_out  output  [0:11]  value to load into AC
ac_wr  output  1  one-cycle AC load strobe
skip  output  1  PC increment request, valid while done=1
halt  output  1  processor halted
trap  output  1  one-cycle user-mode trap pulse
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset=0):
  - State returns to IDLE.
  - All outputs are 0, including ac_out=0000.
  - Captured registers are cleared.
  - Reset asserted mid-sequence (including HALT) aborts immediately; no done pulse is produced.
- Group-2 decode: instruction[0:3]=1111 and instruction[11]=0.
  - start with a non-group-2 word is ignored; the block stays IDLE.
  - start while busy=1 is ignored.
- IDLE, on a valid start:
  - Capture instruction, ac, l and user_mode.
  - Compute ac_zero = (ac==0000) into a register.
  - Go to EVAL; busy=1 from the next cycle.
- EVAL (1 cycle):
  - skip_r = (!i[8] & ((i[5]&ac[0]) | (i[6]&ac_zero) | (i[7]&l))) | (i[8] & !(i[5]&ac[0]) & !(i[6]&ac_zero) & !(i[7]&l)).
  - Every skip test uses the captured AC, never a post-CLA value.
  - If i[4] (CLA): ac_out=0000, ac_wr=1, working AC=0000.
  - If USER_TRAP_EN and user_mode and (i[9] or i[10]): trap=1 for this cycle. OSR and HLT are suppressed; skip and CLA still execute. Go to DONE.
  - Otherwise: go to OSR if i[9], else HALT if i[10], else DONE.
- OSR (1 cycle):
  - ac_out = working AC | sr (bitwise), ac_wr=1.
  - Go to HALT if i[10], else DONE.
- HALT:
  - halt=1; the state holds while cont=0.
  - cont=1 in a cycle means halt drops next cycle, then go to DONE.
  - cont already high on entry means one cycle in HALT, then DONE.
- DONE (1 cycle):
  - done=1, skip=skip_r.
  - busy drops next cycle and the state returns to IDLE.
  - skip returns to 0 after DONE.
  - start during DONE is ignored.
- Latency, start at cycle 0:
  - EVAL at cycle 1, done at cycle 2 (no OSR/HLT).
  - Done at cycle 3 with OSR.
  - With HLT, done comes 1 cycle after the cont-sample cycle.
- Handshake and signal rules:
  - ac_wr is never asserted outside EVAL/OSR.
  - There are at most 2 ac_wr pulses per instruction.
  - ac_out holds its last written value between strobes.
  - halt is never asserted in user-trap sequences.

Test Plan:
- 7500 (SMA), ac=4000, l=0 -> done at cycle 2, skip=1, no ac_wr. Repeat with 7510 (SPA) -> skip=0. Repeat with 7410 (SKP), ac=0001 -> skip=1.
- 7640 (SZA CLA), ac=0000 -> ac_wr in EVAL with ac_out=0000, skip=1. Same with ac=0005 -> skip=0 (uses pre-clear AC), ac_wr still pulses.
- 7604 (CLA OSR), ac=7777, sr=1234 -> ac_wr 0000 at cycle 1, then ac_wr with 1234 at cycle 2, done at cycle 3. 7404 (OSR), ac=0700, sr=0017 -> ac_out=0717.
- 7402 (HLT) -> halt=1 held 10 cycles with cont=0. Raise cont -> halt=0, done next cycle. Second run: assert reset during HALT -> halt=0 immediately, no done, next start accepted.
- user_mode=1, 7406 (OSR HLT) -> trap pulse at cycle 1, no ac_wr, no halt, done at cycle 2. Repeat with USER_TRAP_EN=0 -> OSR write plus halt occur normally.
- start with 7200 (group 1), or start while busy -> no busy change, no outputs, sequence in progress unaffected.
